// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit_if
// Description : Request/result bundle between the core and mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface mul_div_unit_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic [4:0]  Dest_Reg;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  Result_Reg;

    modport master (
        output Start, Op, Operand_A, Operand_B, Dest_Reg,
        input  Busy, Done, Result, Result_Reg
    );

    modport slave (
        input  Start, Op, Operand_A, Operand_B, Dest_Reg,
        output Busy, Done, Result, Result_Reg
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative 32-bit unsigned multiply/divide unit, 32 steps/op.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
    input  wire logic     Clk,
    input  wire logic     Reset,
    mul_div_unit_if.slave mdu
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic        r_sel_high;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [4:0]  r_dest;
    logic [5:0]  r_count;
    logic [63:0] r_acc;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;
    logic [4:0]  r_result_reg;

    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;
    logic [32:0] w_div_shift;
    logic [32:0] w_div_trial;
    logic        w_div_ok;
    logic [63:0] w_div_next;
    logic [63:0] w_step;

    // Multiply: r_acc is the 64-bit product, built LSB-first from the top half down.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_b[0] ? r_a : 32'd0)};
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: r_acc[63:32] is the partial remainder, r_acc[31:0] collects quotient bits.
    // A set shift[32] already exceeds any divisor, so the subtraction must succeed.
    assign w_div_shift = {r_acc[63:32], r_a[31]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ok    = w_div_shift[32] | ~w_div_trial[32];
    assign w_div_next  = {(w_div_ok ? w_div_trial[31:0] : w_div_shift[31:0]),
                          r_acc[30:0], w_div_ok};

    assign w_step = (r_state == S_MUL) ? w_mul_next : w_div_next;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_sel_high   <= 1'b0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_dest       <= 5'd0;
            r_count      <= 6'd0;
            r_acc        <= 64'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_result     <= 32'd0;
            r_result_reg <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (mdu.Start) begin
                        r_sel_high <= mdu.Op[0];
                        r_a        <= mdu.Operand_A;
                        r_b        <= mdu.Operand_B;
                        r_dest     <= mdu.Dest_Reg;
                        r_count    <= 6'd0;
                        r_acc      <= 64'd0;
                        r_busy     <= 1'b1;
                        r_state    <= mdu.Op[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc   <= w_step;
                    r_count <= r_count + 6'd1;
                    if (r_state == S_MUL) begin
                        r_b <= {1'b0, r_b[31:1]};
                    end else begin
                        r_a <= {r_a[30:0], 1'b0};
                    end
                    // Final iteration: the low/high half carries MUL/DIVU vs MULHU/REMU.
                    if (r_count == c_LAST_ITER) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_result     <= r_sel_high ? w_step[63:32] : w_step[31:0];
                        r_result_reg <= r_dest;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mdu.Busy       = r_busy;
    assign mdu.Done       = r_done;
    assign mdu.Result     = r_result;
    assign mdu.Result_Reg = r_result_reg;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: vectors plus random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;
    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .mdu   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Accept one operation, scramble the inputs right after the accept edge,
    // then watch 46 cycles for latency, pulse width, Busy span and hold.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, input logic [31:0] exp,
                          input int inject, input string tag);
        int          done_idx;
        int          pulses;
        int          busy_cnt;
        logic [31:0] res;
        logic [4:0]  rr;
        done_idx = -1;
        pulses   = 0;
        busy_cnt = 0;
        res      = 32'd0;
        rr       = 5'd0;
        @(negedge Clk);
        bus.Start     = 1'b1;
        bus.Op        = op;
        bus.Operand_A = a;
        bus.Operand_B = b;
        bus.Dest_Reg  = dest;
        @(negedge Clk);
        bus.Start     = 1'b0;
        bus.Op        = 2'($urandom);
        bus.Operand_A = $urandom;
        bus.Operand_B = $urandom;
        bus.Dest_Reg  = 5'($urandom);
        for (int i = 0; i < 46; i++) begin
            if (i > 0) @(negedge Clk);
            if (bus.Busy) busy_cnt++;
            if (bus.Done) begin
                pulses++;
                if (done_idx < 0) begin
                    done_idx = i;
                    res      = bus.Result;
                    rr       = bus.Result_Reg;
                end
            end
            if (i == inject) begin
                bus.Start     = 1'b1;
                bus.Op        = 2'b00;
                bus.Operand_A = 32'd9;
                bus.Operand_B = 32'd9;
                bus.Dest_Reg  = 5'd7;
            end else if (i == inject + 1) begin
                bus.Start = 1'b0;
            end
        end
        check({tag, " done_edge"},  64'(done_idx), 64'd32);
        check({tag, " done_count"}, 64'(pulses),   64'd1);
        check({tag, " busy_span"},  64'(busy_cnt), 64'd33);
        check({tag, " result"},     {32'd0, res},  {32'd0, exp});
        check({tag, " result_reg"}, {59'd0, rr},   {59'd0, dest});
        check({tag, " result_hold"}, {32'd0, bus.Result}, {32'd0, exp});
        check({tag, " reg_hold"},   {59'd0, bus.Result_Reg}, {59'd0, dest});
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        Reset         = 1'b0;
        bus.Start     = 1'b0;
        bus.Op        = 2'b00;
        bus.Operand_A = 32'd0;
        bus.Operand_B = 32'd0;
        bus.Dest_Reg  = 5'd0;

        vecs[0] = '{2'b00, 32'd7,          32'd6,          5'd3,  32'd42,         "mul_7x6"};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'hFFFF_FFFE,  "mulhu_max"};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 32'h0000_0001,  "mul_max"};
        vecs[3] = '{2'b10, 32'd100,        32'd7,          5'd4,  32'd14,         "divu_100_7"};
        vecs[4] = '{2'b11, 32'd100,        32'd7,          5'd5,  32'd2,          "remu_100_7"};
        vecs[5] = '{2'b10, 32'h8000_0000,  32'd1,          5'd31, 32'h8000_0000,  "divu_msb_1"};
        vecs[6] = '{2'b10, 32'h0000_1234,  32'd0,          5'd0,  32'hFFFF_FFFF,  "divu_by0"};
        vecs[7] = '{2'b11, 32'h0000_1234,  32'd0,          5'd1,  32'h0000_1234,  "remu_by0"};

        // Reset state
        repeat (2) @(negedge Clk);
        check("reset busy",       {63'd0, bus.Busy}, 64'd0);
        check("reset done",       {63'd0, bus.Done}, 64'd0);
        check("reset result",     {32'd0, bus.Result}, 64'd0);
        check("reset result_reg", {59'd0, bus.Result_Reg}, 64'd0);
        Reset = 1'b1;

        foreach (vecs[k])
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].dest, vecs[k].exp, -1, vecs[k].name);

        // Start pulse mid-operation must be ignored
        run_op(2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 5, "mul_ignore_start");

        // Start held high: back-to-back operations every 34 cycles
        begin
            int first_done;
            int second_done;
            first_done  = -1;
            second_done = -1;
            @(negedge Clk);
            bus.Start     = 1'b1;
            bus.Op        = 2'b00;
            bus.Operand_A = 32'd2;
            bus.Operand_B = 32'd3;
            bus.Dest_Reg  = 5'd9;
            for (int i = 0; i < 80; i++) begin
                @(negedge Clk);
                if (bus.Done) begin
                    if (first_done < 0) first_done = i;
                    else if (second_done < 0) second_done = i;
                end
            end
            bus.Start = 1'b0;
            check("throughput spacing", 64'(second_done - first_done), 64'd34);
            check("throughput result",  {32'd0, bus.Result}, 64'd6);
            repeat (40) @(negedge Clk);
        end

        // Reset during iteration 10 of a DIVU aborts it without a Done
        begin
            int stray_done;
            stray_done = 0;
            @(negedge Clk);
            bus.Start     = 1'b1;
            bus.Op        = 2'b10;
            bus.Operand_A = 32'd1000;
            bus.Operand_B = 32'd3;
            bus.Dest_Reg  = 5'd12;
            @(negedge Clk);
            bus.Start = 1'b0;
            repeat (9) @(negedge Clk);
            Reset = 1'b0;
            @(negedge Clk);
            check("abort busy",       {63'd0, bus.Busy}, 64'd0);
            check("abort done",       {63'd0, bus.Done}, 64'd0);
            check("abort result",     {32'd0, bus.Result}, 64'd0);
            check("abort result_reg", {59'd0, bus.Result_Reg}, 64'd0);
            Reset = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge Clk);
                if (bus.Done) stray_done++;
            end
            check("abort no_done", 64'(stray_done), 64'd0);
            run_op(2'b00, 32'd3, 32'd5, 5'd2, 32'd15, -1, "mul_after_abort");
        end

        // Randomised operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  d;
            int          kind;
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0)      b = 32'd0;
            else if (kind == 1) b = $urandom_range(1, 15);
            else                b = $urandom;
            if (kind == 2) a = $urandom_range(0, 255);
            d = 5'($urandom);
            run_op(op, a, b, d, ref_model(op, a, b), -1, $sformatf("rand%0d_op%0d", n, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
